trng_collector: RTL

TRNG_COLLECTOR -- requirements
Module: trng_collector

---
 rtl/trng_collector.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/trng_collector.sv
`default_nettype none
// ============================================================================
// Module   : trng_collector
// Brief    : Warms up a raw TRNG source, Von Neumann debiases its samples into
//            words, and guards the source with a repetition-count health test.
// Revision : 1.0 - initial release
// ============================================================================
module trng_collector #(
    parameter int WORD_WIDTH    = 32,
    parameter int WARMUP_CYCLES = 64,
    parameter int RCT_CUTOFF    = 40
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear_fail,
    input  logic                  raw_bit,
    output logic                  trng_en,
    output logic [WORD_WIDTH-1:0] word,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic                  health_fail
);

    localparam int                c_cnt_w     = $clog2(WORD_WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_word_cnt = c_cnt_w'(WORD_WIDTH);
    localparam logic [9:0]        c_warm_last = 10'(WARMUP_CYCLES - 1);
    localparam logic [7:0]        c_rct_cut   = 8'(RCT_CUTOFF);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WARMUP  = 2'd1,
        COLLECT = 2'd2,
        FAIL    = 2'd3
    } state_t;

    state_t                r_state_q,   w_state_d;
    logic                  r_trng_en_q, w_trng_en_d;
    logic [WORD_WIDTH-1:0] r_word_q,    w_word_d;
    logic                  r_valid_q,   w_valid_d;
    logic                  r_fail_q,    w_fail_d;
    logic [9:0]            r_warm_q,    w_warm_d;
    logic [7:0]            r_run_q,     w_run_d;
    logic                  r_prev_q,    w_prev_d;
    logic                  r_phase_q,   w_phase_d;
    logic                  r_first_q,   w_first_d;
    logic [WORD_WIDTH-1:0] r_shreg_q,   w_shreg_d;
    logic [c_cnt_w-1:0]    r_cnt_q,     w_cnt_d;

    logic w_trip;
    logic w_emit;
    logic w_load;

    always_comb begin
        w_state_d   = r_state_q;
        w_word_d    = r_word_q;
        w_valid_d   = r_valid_q;
        w_fail_d    = r_fail_q;
        w_warm_d    = r_warm_q;
        w_run_d     = r_run_q;
        w_prev_d    = r_prev_q;
        w_phase_d   = r_phase_q;
        w_first_d   = r_first_q;
        w_shreg_d   = r_shreg_q;
        w_cnt_d     = r_cnt_q;
        w_trng_en_d = (r_state_q == WARMUP) || (r_state_q == COLLECT);

        w_trip = (r_state_q == COLLECT) && (r_run_q == c_rct_cut);
        w_emit = (r_state_q == COLLECT) && r_phase_q && (r_first_q != raw_bit);
        w_load = (r_state_q == COLLECT) && enable && !w_trip &&
                 (r_cnt_q == c_word_cnt) && (!r_valid_q || word_ready);

        if (r_valid_q && word_ready) begin
            w_valid_d = 1'b0;
        end
        if (w_load) begin
            w_word_d  = r_shreg_q;
            w_valid_d = 1'b1;
            w_cnt_d   = '0;
        end
        // A full shift register swallows new bits until its word is taken.
        if (w_emit && (r_cnt_q != c_word_cnt)) begin
            w_shreg_d = {r_shreg_q[WORD_WIDTH-2:0], r_first_q};
            w_cnt_d   = r_cnt_q + 1'b1;
        end

        unique case (r_state_q)
            IDLE: begin
                if (enable) begin
                    w_state_d = WARMUP;
                    w_warm_d  = '0;
                end
            end
            WARMUP: begin
                if (!enable) begin
                    w_state_d = IDLE;
                    w_shreg_d = '0;
                    w_cnt_d   = '0;
                end else if (r_warm_q == c_warm_last) begin
                    w_state_d = COLLECT;
                    w_phase_d = 1'b0;
                    w_run_d   = '0;
                end else begin
                    w_warm_d = r_warm_q + 1'b1;
                end
            end
            COLLECT: begin
                if (w_trip) begin
                    w_state_d = FAIL;
                    w_fail_d  = 1'b1;
                    w_valid_d = 1'b0;
                    w_shreg_d = '0;
                    w_cnt_d   = '0;
                end else if (!enable) begin
                    w_state_d = IDLE;
                    w_shreg_d = '0;
                    w_cnt_d   = '0;
                    w_phase_d = 1'b0;
                end else begin
                    w_phase_d = !r_phase_q;
                    if (!r_phase_q) begin
                        w_first_d = raw_bit;
                    end
                    if ((r_run_q == '0) || (raw_bit != r_prev_q)) begin
                        w_run_d = 8'd1;
                    end else if (r_run_q != 8'hFF) begin
                        w_run_d = r_run_q + 1'b1;
                    end
                    w_prev_d = raw_bit;
                end
            end
            FAIL: begin
                if (clear_fail) begin
                    w_fail_d  = 1'b0;
                    w_warm_d  = '0;
                    w_state_d = enable ? WARMUP : IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q   <= IDLE;
            r_trng_en_q <= 1'b0;
            r_word_q    <= '0;
            r_valid_q   <= 1'b0;
            r_fail_q    <= 1'b0;
            r_warm_q    <= '0;
            r_run_q     <= '0;
            r_prev_q    <= 1'b0;
            r_phase_q   <= 1'b0;
            r_first_q   <= 1'b0;
            r_shreg_q   <= '0;
            r_cnt_q     <= '0;
        end else begin
            r_state_q   <= w_state_d;
            r_trng_en_q <= w_trng_en_d;
            r_word_q    <= w_word_d;
            r_valid_q   <= w_valid_d;
            r_fail_q    <= w_fail_d;
            r_warm_q    <= w_warm_d;
            r_run_q     <= w_run_d;
            r_prev_q    <= w_prev_d;
            r_phase_q   <= w_phase_d;
            r_first_q   <= w_first_d;
            r_shreg_q   <= w_shreg_d;
            r_cnt_q     <= w_cnt_d;
        end
    end

    assign trng_en     = r_trng_en_q;
    assign word        = r_word_q;
    assign word_valid  = r_valid_q;
    assign health_fail = r_fail_q;

endmodule
`default_nettype wire
